cunit_p: RTL and testbench

Parametrised multicycle control unit, the next generation of the processor's controller. It fetches 16-bit instructions from an external asynchronous-read instruction memory and decodes them. It then sequences the datapath through load, store, add, subtract, conditional jump and halt. The unit sits beside the datapath under the processor top, drives every datapath control line, and exposes IR, PC and state for observation.

---
 rtl/cunit_pkg.sv | 64 ++++++
 rtl/cunit_p_if.sv | 39 +++
 rtl/cunit_decode.sv | 49 ++++
 rtl/cunit_p.sv | 96 +++++++++
 tb/tb_cunit_p.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cunit_pkg.sv
// Shared definitions for the cunit_p control unit: opcodes, state codes,
// ALU selects, IR field positions and the decoded control-line bundle.
package cunit_pkg;

  localparam int unsigned IR_W     = 16;
  localparam int unsigned OPC_W    = 4;
  localparam int unsigned ST_W     = 4;
  localparam int unsigned RADDR_W  = 4;
  localparam int unsigned DADDR_W  = 8;
  localparam int unsigned ALU_W    = 3;
  localparam int unsigned OPND_W   = IR_W - OPC_W;

  // IR field positions; register and address fields sit below the opcode
  localparam int unsigned OPC_LSB     = 12;
  localparam int unsigned RA_LSB      = 8;
  localparam int unsigned RB_LSB      = 4;
  localparam int unsigned RD_LSB      = 0;
  localparam int unsigned LD_ADDR_LSB = 4;
  localparam int unsigned ST_ADDR_LSB = 0;

  localparam logic [OPC_W-1:0] OP_NOOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_STORE = 4'h1;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'h4;
  localparam logic [OPC_W-1:0] OP_HALT  = 4'h5;
  localparam logic [OPC_W-1:0] OP_JMPZ  = 4'h6;

  localparam logic [ALU_W-1:0] ALU_PASS = 3'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'd1;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'd2;

  typedef enum logic [ST_W-1:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_B = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_HALT   = 4'd9,
    ST_JMPZ   = 4'd10
  } state_e;

  typedef struct packed {
    logic [DADDR_W-1:0] d_addr;
    logic               d_wr;
    logic               rf_s;
    logic [RADDR_W-1:0] rf_w_addr;
    logic               rf_w_wr;
    logic [RADDR_W-1:0] rf_ra_addr;
    logic               rf_ra_rd;
    logic [RADDR_W-1:0] rf_rb_addr;
    logic               rf_rb_rd;
    logic [ALU_W-1:0]   alu_s0;
  } ctrl_t;

  function automatic logic [OPC_W-1:0] ir_opcode(input logic [IR_W-1:0] ir);
    return ir[OPC_LSB +: OPC_W];
  endfunction

endpackage

// File: rtl/cunit_p_if.sv
// Bus between the control unit and the datapath / instruction memory,
// plus the IR, PC and state observation lines.
interface cunit_p_if #(
  parameter int unsigned PC_W = 5
);
  import cunit_pkg::*;

  logic [PC_W-1:0]    Imem_addr;
  logic [IR_W-1:0]    Imem_data;
  logic               Rf_zero;
  logic [DADDR_W-1:0] D_addr;
  logic               D_wr;
  logic               RF_s;
  logic [RADDR_W-1:0] RF_W_addr;
  logic               RF_W_wr;
  logic [RADDR_W-1:0] RF_Ra_addr;
  logic [RADDR_W-1:0] RF_Rb_addr;
  logic               RF_Ra_rd;
  logic               RF_Rb_rd;
  logic [ALU_W-1:0]   Alu_s0;
  logic [IR_W-1:0]    IR_Out;
  logic [PC_W-1:0]    PC_Out;
  logic [ST_W-1:0]    StateO;

  modport master (
    output Imem_addr, D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr,
           RF_Ra_addr, RF_Rb_addr, RF_Ra_rd, RF_Rb_rd, Alu_s0,
           IR_Out, PC_Out, StateO,
    input  Imem_data, Rf_zero
  );

  modport slave (
    input  Imem_addr, D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr,
           RF_Ra_addr, RF_Rb_addr, RF_Ra_rd, RF_Rb_rd, Alu_s0,
           IR_Out, PC_Out, StateO,
    output Imem_data, Rf_zero
  );

endinterface

// File: rtl/cunit_decode.sv
// Combinational control-line decoder: current state plus IR operand field
// to every datapath control line; all lines are zero outside their state.
module cunit_decode
  import cunit_pkg::*;
(
  input  state_e            state,
  input  logic [OPND_W-1:0] operand,
  output ctrl_t             ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    case (state)
      ST_LOAD_A: begin
        ctrl_c.d_addr = operand[LD_ADDR_LSB +: DADDR_W];
      end
      // address stays on the bus while memory data is written back
      ST_LOAD_B: begin
        ctrl_c.d_addr    = operand[LD_ADDR_LSB +: DADDR_W];
        ctrl_c.rf_s      = 1'b1;
        ctrl_c.rf_w_addr = operand[RD_LSB +: RADDR_W];
        ctrl_c.rf_w_wr   = 1'b1;
      end
      ST_STORE: begin
        ctrl_c.d_addr     = operand[ST_ADDR_LSB +: DADDR_W];
        ctrl_c.rf_ra_addr = operand[RA_LSB +: RADDR_W];
        ctrl_c.rf_ra_rd   = 1'b1;
        ctrl_c.d_wr       = 1'b1;
        ctrl_c.alu_s0     = ALU_PASS;
      end
      ST_ADD, ST_SUB: begin
        ctrl_c.rf_ra_addr = operand[RA_LSB +: RADDR_W];
        ctrl_c.rf_rb_addr = operand[RB_LSB +: RADDR_W];
        ctrl_c.rf_w_addr  = operand[RD_LSB +: RADDR_W];
        ctrl_c.rf_ra_rd   = 1'b1;
        ctrl_c.rf_rb_rd   = 1'b1;
        ctrl_c.rf_w_wr    = 1'b1;
        ctrl_c.rf_s       = 1'b0;
        ctrl_c.alu_s0     = (state == ST_ADD) ? ALU_ADD : ALU_SUB;
      end
      ST_JMPZ: begin
        ctrl_c.rf_ra_addr = operand[RA_LSB +: RADDR_W];
        ctrl_c.rf_ra_rd   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cunit_p.sv
// Multicycle control unit: state, PC and IR registers plus next-state logic.
// Define CU_JMPZ_EN to implement JMPZ; otherwise opcode 0110 runs as NOOP.
module cunit_p
  import cunit_pkg::*;
#(
  parameter int unsigned PC_W     = 5,
  parameter int unsigned START_PC = 0
)(
  input  logic      Clk,
  input  logic      Reset,
  cunit_p_if.master bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  ctrl_t           ctrl;

  function automatic state_e exec_state(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_STORE: return ST_STORE;
      OP_LOAD:  return ST_LOAD_A;
      OP_ADD:   return ST_ADD;
      OP_SUB:   return ST_SUB;
      OP_HALT:  return ST_HALT;
`ifdef CU_JMPZ_EN
      OP_JMPZ:  return ST_JMPZ;
`endif
      default:  return ST_NOOP;
    endcase
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_INIT;
      pc_q    <= PC_W'(START_PC);
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH: begin
        ir_d    = bus.Imem_data;
        pc_d    = pc_q + PC_W'(1);
        state_d = ST_DECODE;
      end
      ST_DECODE: state_d = exec_state(ir_opcode(ir_q));
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_HALT:   state_d = ST_HALT;
`ifdef CU_JMPZ_EN
      // target bits above PC_W are dropped by the slice
      ST_JMPZ: begin
        if (bus.Rf_zero) pc_d = ir_q[PC_W-1:0];
        state_d = ST_FETCH;
      end
`endif
      default:   state_d = ST_FETCH;
    endcase
  end

`ifndef CU_JMPZ_EN
  logic unused_rf_zero;
  assign unused_rf_zero = bus.Rf_zero;
`endif

  cunit_decode u_decode (
    .state   (state_q),
    .operand (ir_q[OPND_W-1:0]),
    .ctrl_c  (ctrl)
  );

  assign bus.Imem_addr  = pc_q;
  assign bus.PC_Out     = pc_q;
  assign bus.IR_Out     = ir_q;
  assign bus.StateO     = ST_W'(state_q);
  assign bus.D_addr     = ctrl.d_addr;
  assign bus.D_wr       = ctrl.d_wr;
  assign bus.RF_s       = ctrl.rf_s;
  assign bus.RF_W_addr  = ctrl.rf_w_addr;
  assign bus.RF_W_wr    = ctrl.rf_w_wr;
  assign bus.RF_Ra_addr = ctrl.rf_ra_addr;
  assign bus.RF_Rb_addr = ctrl.rf_rb_addr;
  assign bus.RF_Ra_rd   = ctrl.rf_ra_rd;
  assign bus.RF_Rb_rd   = ctrl.rf_rb_rd;
  assign bus.Alu_s0     = ctrl.alu_s0;

endmodule

// File: tb/tb_cunit_p.sv
// Directed self-checking bench for cunit_p (PC_W=5, START_PC=0); expectations
// follow CU_JMPZ_EN when it is defined for the build.
module tb_cunit_p;

  localparam int unsigned PC_W = 5;

`ifdef CU_JMPZ_EN
  localparam logic [3:0] EXP_JMPZ_ST = 4'd10;
  localparam logic       EXP_JMPZ_RD = 1'b1;
  localparam logic [4:0] EXP_PC_TGT  = 5'd9;
  localparam logic [4:0] EXP_PC_HALT = 5'd10;
`else
  localparam logic [3:0] EXP_JMPZ_ST = 4'd3;
  localparam logic       EXP_JMPZ_RD = 1'b0;
  localparam logic [4:0] EXP_PC_TGT  = 5'd6;
  localparam logic [4:0] EXP_PC_HALT = 5'd7;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rf_zero = 1'b0;
  logic [15:0] imem [32];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  cunit_p_if #(.PC_W(PC_W)) bus ();

  assign bus.Imem_data = imem[bus.Imem_addr];
  assign bus.Rf_zero   = rf_zero;

  cunit_p #(.PC_W(PC_W), .START_PC(0)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_program();
    foreach (imem[i]) imem[i] = 16'h0000;
    imem[0] = 16'h21B3;
    imem[1] = 16'h1A5C;
    imem[2] = 16'h3120;
    imem[3] = 16'h4312;
    imem[4] = 16'h6209;
    imem[5] = 16'h62E9;
    imem[6] = 16'h5000;
    imem[9] = 16'h5000;
  endtask

  logic [3:0] exp_st [6];
  logic [4:0] exp_pc [6];
  logic       strobe_seen;

  initial begin
    exp_st = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};
    exp_pc = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd2, 5'd2};

    // NOOP stream, reset values, then PC wrap
    foreach (imem[i]) imem[i] = 16'h0000;
    #13;
    check("rst_state", bus.StateO, 4'd0);
    check("rst_pc", bus.PC_Out, 5'd0);
    check("rst_ir", bus.IR_Out, 16'h0000);
    check("rst_strobes", {bus.D_wr, bus.RF_W_wr, bus.RF_Ra_rd}, 3'b000);
    release_reset();
    #1;
    check("init_state", bus.StateO, 4'd0);
    strobe_seen = 1'b0;
    for (int e = 0; e < 6; e++) begin
      tick(1);
      check("noop_state", bus.StateO, exp_st[e]);
      check("noop_pc", bus.PC_Out, exp_pc[e]);
      strobe_seen |= bus.D_wr | bus.RF_W_wr;
    end
    for (int e = 6; e < 94; e++) begin
      tick(1);
      strobe_seen |= bus.D_wr | bus.RF_W_wr;
    end
    check("noop_no_strobe", strobe_seen, 1'b0);
    check("wrap_fetch31_state", bus.StateO, 4'd1);
    check("wrap_fetch31_addr", bus.Imem_addr, 5'd31);
    tick(3);
    check("wrap_fetch0_state", bus.StateO, 4'd1);
    check("wrap_fetch0_addr", bus.Imem_addr, 5'd0);

    // program: LOAD, STORE, ADD, SUB, JMPZ not taken, JMPZ taken, HALT
    rst_n = 1'b0;
    load_program();
    rf_zero = 1'b0;
    #3;
    release_reset();
    tick(2);
    check("ld_ir", bus.IR_Out, 16'h21B3);
    check("ld_decode_pc", bus.PC_Out, 5'd1);
    tick(1);
    check("lda_state", bus.StateO, 4'd4);
    check("lda_daddr", bus.D_addr, 8'h1B);
    check("lda_wwr", bus.RF_W_wr, 1'b0);
    tick(1);
    check("ldb_state", bus.StateO, 4'd5);
    check("ldb_daddr", bus.D_addr, 8'h1B);
    check("ldb_rfs", bus.RF_s, 1'b1);
    check("ldb_waddr", bus.RF_W_addr, 4'd3);
    check("ldb_wwr", bus.RF_W_wr, 1'b1);
    tick(1);
    check("ld_end_state", bus.StateO, 4'd1);
    check("ld_end_wwr", bus.RF_W_wr, 1'b0);
    tick(2);
    check("st_state", bus.StateO, 4'd6);
    check("st_ctrl", {bus.D_addr, bus.RF_Ra_addr, bus.RF_Ra_rd, bus.D_wr, bus.Alu_s0, bus.RF_W_wr},
          {8'h5C, 4'hA, 1'b1, 1'b1, 3'd0, 1'b0});
    tick(1);
    check("st_end_dwr", bus.D_wr, 1'b0);
    tick(2);
    check("add_state", bus.StateO, 4'd7);
    check("add_ctrl", {bus.Alu_s0, bus.RF_Ra_addr, bus.RF_Rb_addr, bus.RF_W_addr,
                       bus.RF_Ra_rd, bus.RF_Rb_rd, bus.RF_W_wr, bus.RF_s, bus.D_wr},
          {3'd1, 4'd1, 4'd2, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    tick(3);
    check("sub_state", bus.StateO, 4'd8);
    check("sub_ctrl", {bus.Alu_s0, bus.RF_Ra_addr, bus.RF_Rb_addr, bus.RF_W_addr,
                       bus.RF_Ra_rd, bus.RF_Rb_rd, bus.RF_W_wr, bus.RF_s},
          {3'd2, 4'd3, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0});
    tick(3);
    check("jz0_state", bus.StateO, EXP_JMPZ_ST);
    check("jz0_rard", bus.RF_Ra_rd, EXP_JMPZ_RD);
    check("jz0_wwr", bus.RF_W_wr, 1'b0);
    tick(1);
    check("jz0_next_state", bus.StateO, 4'd1);
    check("jz0_next_pc", bus.PC_Out, 5'd5);
    rf_zero = 1'b1;
    tick(2);
    check("jz1_state", bus.StateO, EXP_JMPZ_ST);
    tick(1);
    check("jz1_next_pc", bus.PC_Out, EXP_PC_TGT);
    tick(2);
    check("halt_state", bus.StateO, 4'd9);
    check("halt_pc", bus.PC_Out, EXP_PC_HALT);
    strobe_seen = 1'b0;
    for (int e = 0; e < 100; e++) begin
      tick(1);
      strobe_seen |= bus.D_wr | bus.RF_W_wr | (bus.StateO != 4'd9) | (bus.PC_Out != EXP_PC_HALT);
    end
    check("halt_held_100", strobe_seen, 1'b0);
    check("halt_state_end", bus.StateO, 4'd9);

    // asynchronous reset in LOAD_B, then restart
    rst_n = 1'b0;
    rf_zero = 1'b0;
    #3;
    release_reset();
    tick(4);
    check("pre_rst_ldb", bus.RF_W_wr, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", bus.StateO, 4'd0);
    check("mid_rst_ctrl", {bus.RF_W_wr, bus.RF_s, bus.D_addr, bus.RF_W_addr}, 14'd0);
    check("mid_rst_pc", bus.PC_Out, 5'd0);
    check("mid_rst_ir", bus.IR_Out, 16'h0000);
    release_reset();
    tick(2);
    check("restart_ir", bus.IR_Out, 16'h21B3);
    check("restart_pc", bus.PC_Out, 5'd1);
    tick(2);
    check("restart_ldb", {bus.StateO, bus.RF_W_wr, bus.RF_W_addr}, {4'd5, 1'b1, 4'd3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
